// File: rtl/smu_bus_pkg.sv
// Shared types and memory-map constants for the data-bus fabric.
// Imported by smu_addr_decode and smu_bus_fabric.
package smu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } bus_state_t;

    localparam logic ERR_RDATA = 1'b0;

    localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
    localparam logic [31:0] DMEM_MASK  = 32'hFFFF_C000;
    localparam logic [31:0] TBMAN_BASE = 32'h8000_0000;
    localparam logic [31:0] TBMAN_MASK = 32'hFFFF_0000;
    localparam logic [31:0] TIMER_BASE = 32'h4000_0000;
    localparam logic [31:0] TIMER_MASK = 32'hFFFF_FF00;
    localparam logic [31:0] GPIO_BASE  = 32'h4000_0100;
    localparam logic [31:0] GPIO_MASK  = 32'hFFFF_FF00;
    localparam logic [31:0] UART_BASE  = 32'h4000_0200;
    localparam logic [31:0] UART_MASK  = 32'hFFFF_FF00;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/smu_addr_decode.sv
// Base/mask address compare with lowest-index priority.
// Produces hit flag, binary select index and one-hot select.
module smu_addr_decode
    import smu_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int AWIDTH     = 32,
    parameter int SELW       = 2,
    parameter logic [NUM_SLAVES*AWIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*AWIDTH-1:0] SLV_MASK = '0
) (
    input  logic [AWIDTH-1:0]     addr_i,
    output logic                  hit_o,
    output logic [SELW-1:0]       sel_o,
    output logic [NUM_SLAVES-1:0] onehot_o
);

    logic [NUM_SLAVES-1:0] match;

    // full-width compare of every slave window
    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            match[i] = ((addr_i & SLV_MASK[i*AWIDTH +: AWIDTH])
                        == SLV_BASE[i*AWIDTH +: AWIDTH]);
        end
    end

    // priority encode: scanning downward leaves the lowest hit
    always_comb begin
        sel_o = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) sel_o = SELW'(i);
        end
    end

    assign hit_o    = |match;
    assign onehot_o = match & (~match + NUM_SLAVES'(1));

endmodule

// File: rtl/smu_bus_fabric.sv
// Memory-mapped data-bus fabric: decode, wait states, error responses.
// Define BUS_TIMEOUT_EN to enable the WAIT-state timeout counter.
module smu_bus_fabric
    import smu_bus_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter logic [NUM_SLAVES*AWIDTH-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*AWIDTH-1:0] SLV_MASK = '0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [AWIDTH-1:0]            m_addr,
    input  logic [DWIDTH-1:0]            m_wdata,
    input  logic [DWIDTH/8-1:0]          m_be,
    output logic [DWIDTH-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_cs_n,
    output logic                         s_we,
    output logic [AWIDTH-1:0]            s_addr,
    output logic [DWIDTH-1:0]            s_wdata,
    output logic [DWIDTH/8-1:0]          s_be,
    input  logic [NUM_SLAVES*DWIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    output logic [AWIDTH-1:0]            err_addr
);

    localparam int SELW = sel_width(NUM_SLAVES);

    bus_state_t            state_q, state_d;
    logic [SELW-1:0]       sel_q, sel_d;
    logic [AWIDTH-1:0]     err_addr_q, err_addr_d;

    logic                  dec_hit;
    logic [SELW-1:0]       dec_sel;
    logic [NUM_SLAVES-1:0] dec_oh;
    logic [NUM_SLAVES-1:0] sel_oh;
    logic [NUM_SLAVES-1:0] cs_oh, cs_g;
    logic                  ready_c, err_c;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]            cnt_q, cnt_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    smu_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .AWIDTH     (AWIDTH),
        .SELW       (SELW),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .addr_i   (m_addr),
        .hit_o    (dec_hit),
        .sel_o    (dec_sel),
        .onehot_o (dec_oh)
    );

    assign sel_oh = NUM_SLAVES'(1) << sel_q;

    // next-state, select and response generation
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        err_addr_d = err_addr_q;
        cs_oh      = '0;
        ready_c    = 1'b0;
        err_c      = 1'b0;
`ifdef BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (m_req) begin
                    if (dec_hit) begin
                        cs_oh = dec_oh;
                        if (|(s_ready & dec_oh)) begin
                            ready_c = 1'b1;
                        end else begin
                            state_d = WAIT;
                            sel_d   = dec_sel;
`ifdef BUS_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end else begin
                        state_d    = ERR;
                        err_addr_d = m_addr;
                    end
                end
            end
            WAIT: begin
                if (!m_req) begin
                    state_d = IDLE;
                end else begin
                    cs_oh = sel_oh;
                    if (|(s_ready & sel_oh)) begin
                        ready_c = 1'b1;
                        state_d = IDLE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (cnt_q == TC_LAST) begin
                        state_d    = ERR;
                        err_addr_d = m_addr;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end
            ERR: begin
                ready_c = 1'b1;
                err_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // reset forces every strobe inactive without waiting for a clock
    always_comb begin
        cs_g    = reset ? '0 : cs_oh;
        m_ready = ready_c & ~reset;
        m_err   = err_c & ~reset;
    end

    // AND-OR read-data mux, zero unless a slave completes
    always_comb begin
        m_rdata = {DWIDTH{ERR_RDATA}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            m_rdata = m_rdata | (s_rdata[i*DWIDTH +: DWIDTH]
                      & {DWIDTH{cs_g[i] & m_ready}});
        end
    end

    assign s_cs_n   = ~cs_g;
    assign s_we     = m_we & (|cs_g);
    assign s_addr   = m_addr;
    assign s_wdata  = m_wdata;
    assign s_be     = m_be;
    assign err_addr = err_addr_q;

    // state, latched select and error address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            err_addr_q <= err_addr_d;
        end
    end

`ifdef BUS_TIMEOUT_EN
    // wait-state counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_smu_bus_fabric.sv
// Self-checking bench for smu_bus_fabric: vector table, corner
// sequences and randomized transactions against a transaction model.
module tb_smu_bus_fabric;

    localparam int NS = 4;
    localparam int TO = 16;
    localparam logic [31:0] B0 = 32'h1000_0000, M0 = 32'hFFFF_C000;
    localparam logic [31:0] B1 = 32'h2000_0000, M1 = 32'hFFFF_0000;
    localparam logic [31:0] B2 = 32'h3000_0000, M2 = 32'hFFFF_0000;
    localparam logic [31:0] B3 = 32'h2000_0000, M3 = 32'hFF00_0000;
`ifdef BUS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk, reset;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic        m_ready, m_err;
    logic [3:0]  s_cs_n;
    logic        s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic [127:0] s_rdata;
    logic [3:0]  s_ready;
    logic [31:0] err_addr;

    logic [31:0] srd [4];
    logic [31:0] bases [4];
    logic [31:0] masks [4];
    logic [31:0] exp_err_addr;
    int n_cmp, n_bad;

    assign s_rdata = {srd[3], srd[2], srd[1], srd[0]};

    smu_bus_fabric #(
        .NUM_SLAVES     (NS),
        .AWIDTH         (32),
        .DWIDTH         (32),
        .SLV_BASE       ({B3, B2, B1, B0}),
        .SLV_MASK       ({M3, M2, M1, M0}),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_be     (m_be),
        .m_rdata  (m_rdata),
        .m_ready  (m_ready),
        .m_err    (m_err),
        .s_cs_n   (s_cs_n),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_be     (s_be),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wd;
        logic [3:0]  be;
        int          dly;
        logic [31:0] sd;
        logic [3:0]  ecs;
        logic        eerr;
        int          elat;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // one access; the target slave raises ready from cycle dly onward
    task automatic run_txn(input logic [31:0] a, input logic we,
                           input logic [31:0] wd, input logic [3:0] be,
                           input int dly, input logic [31:0] sd,
                           input logic [3:0] ecs, input logic eerr,
                           input int elat);
        int t;
        t = -1;
        for (int i = 0; i < NS; i++) if (!ecs[i]) t = i;
        for (int i = 0; i < NS; i++) srd[i] = $urandom;
        if (t >= 0) srd[t] = sd;
        m_req = 1'b1; m_we = we; m_addr = a; m_wdata = wd; m_be = be;
        for (int c = 0; c <= elat; c++) begin
            s_ready = 4'($urandom);
            if (t >= 0) s_ready[t] = (c >= dly);
            @(negedge clk);
            if (c < elat) begin
                check("cs_n_wait", 32'(s_cs_n), 32'(ecs));
                check("ready_wait", 32'(m_ready), 32'd0);
                check("rdata_wait", m_rdata, 32'd0);
                check("we_wait", 32'(s_we), 32'(we & (ecs != 4'hF)));
            end else begin
                check("ready_done", 32'(m_ready), 32'd1);
                check("err_done", 32'(m_err), 32'(eerr));
                check("rdata_done", m_rdata, eerr ? 32'd0 : sd);
                check("cs_n_done", 32'(s_cs_n), eerr ? 32'hF : 32'(ecs));
                check("we_done", 32'(s_we), 32'(we & ~eerr));
                check("s_addr", s_addr, a);
                check("s_wdata", s_wdata, wd);
                check("s_be", 32'(s_be), 32'(be));
                if (eerr) exp_err_addr = a;
                check("err_addr", err_addr, exp_err_addr);
            end
            @(posedge clk); #1;
        end
        m_req = 1'b0;
    endtask

    task automatic idle_cycle();
        m_req = 1'b0;
        s_ready = 4'($urandom);
        @(negedge clk);
        check("cs_n_idle", 32'(s_cs_n), 32'hF);
        check("ready_idle", 32'(m_ready), 32'd0);
        check("rdata_idle", m_rdata, 32'd0);
        @(posedge clk); #1;
    endtask

    function automatic int find_slave(input logic [31:0] a);
        for (int i = 0; i < NS; i++)
            if ((a & masks[i]) == bases[i]) return i;
        return -1;
    endfunction

    initial begin
        int k, t, dly, elat;
        logic [31:0] a;
        logic [3:0] ecs;
        logic eerr;

        n_cmp = 0; n_bad = 0; exp_err_addr = 32'd0;
        bases = '{B0, B1, B2, B3};
        masks = '{M0, M1, M2, M3};
        for (int i = 0; i < NS; i++) srd[i] = 32'hDEAD_0000 + 32'(i);

        tbl[0] = '{32'h1000_0010, 1'b0, 32'h0, 4'hF, 0, 32'h1234_5678, 4'b1110, 1'b0, 0};
        tbl[1] = '{32'h3000_0040, 1'b1, 32'hCAFE_F00D, 4'b0011, 3, 32'h0BAD_0BAD, 4'b1011, 1'b0, 3};
        tbl[2] = '{32'hF000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h55AA_55AA, 4'b1111, 1'b1, 1};
        tbl[3] = '{32'h2000_0100, 1'b0, 32'h0, 4'hF, 2, 32'hA5A5_0001, 4'b1101, 1'b0, 2};
        tbl[4] = '{32'h20FF_0000, 1'b0, 32'h0, 4'hF, 0, 32'h3333_3333, 4'b0111, 1'b0, 0};
        tbl[5] = '{32'h1000_3FFC, 1'b1, 32'h1122_3344, 4'b1100, 1, 32'h0, 4'b1110, 1'b0, 1};
        tbl[6] = '{32'h1000_4000, 1'b0, 32'h0, 4'hF, 0, 32'h77, 4'b1111, 1'b1, 1};
        tbl[7] = '{32'h3000_FFFF, 1'b0, 32'h0, 4'hF, 0, 32'h9999_0000, 4'b1011, 1'b0, 0};

        // reset state with a live request held on the bus
        reset = 1'b1; m_req = 1'b1; m_we = 1'b1;
        m_addr = 32'h1000_0000; m_wdata = 32'h0; m_be = 4'hF;
        s_ready = 4'hF;
        @(negedge clk);
        check("rst_cs_n", 32'(s_cs_n), 32'hF);
        check("rst_ready", 32'(m_ready), 32'd0);
        check("rst_err", 32'(m_err), 32'd0);
        check("rst_we", 32'(s_we), 32'd0);
        check("rst_rdata", m_rdata, 32'd0);
        check("rst_err_addr", err_addr, 32'd0);
        @(posedge clk); #1;
        m_req = 1'b0; reset = 1'b0;
        idle_cycle();

        // vector table, applied back to back
        for (int i = 0; i < 8; i++)
            run_txn(tbl[i].addr, tbl[i].we, tbl[i].wd, tbl[i].be,
                    tbl[i].dly, tbl[i].sd, tbl[i].ecs, tbl[i].eerr,
                    tbl[i].elat);
        idle_cycle();

`ifdef BUS_TIMEOUT_EN
        // timeout, then a back-to-back access to slave 0
        run_txn(32'h2000_0010, 1'b0, 32'h0, 4'hF, 255, 32'h1111_1111,
                4'b1101, 1'b1, TO + 1);
        run_txn(32'h1000_0020, 1'b0, 32'h0, 4'hF, 0, 32'h2222_2222,
                4'b1110, 1'b0, 0);
        // ready at the terminal count wins over the timeout
        run_txn(32'h2000_0020, 1'b1, 32'h0F0F_0F0F, 4'hF, TO, 32'h4444_4444,
                4'b1101, 1'b0, TO);
`else
        // without the timeout a long wait simply completes
        run_txn(32'h2000_0020, 1'b1, 32'h0F0F_0F0F, 4'hF, 25, 32'h4444_4444,
                4'b1101, 1'b0, 25);
`endif
        idle_cycle();

        // reset asserted during a slave 3 wait
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h20FF_0000;
        m_wdata = 32'h5; m_be = 4'hF; s_ready = 4'h0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("pre_rst_cs_n", 32'(s_cs_n), 32'b0111);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check("async_rst_cs_n", 32'(s_cs_n), 32'hF);
        check("async_rst_ready", 32'(m_ready), 32'd0);
        check("async_rst_we", 32'(s_we), 32'd0);
        @(negedge clk);
        check("rst_hold_ready", 32'(m_ready), 32'd0);
        @(posedge clk); #1;
        m_req = 1'b0; reset = 1'b0;
        exp_err_addr = 32'd0;
        check("rst_clr_err_addr", err_addr, exp_err_addr);
        idle_cycle();

        // randomized transactions against the transaction model
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 5);
            if (k < 4)       a = bases[k] | ($urandom & ~masks[k]);
            else if (k == 4) a = 32'h2000_0000 | 32'($urandom_range(0, 16'hFFFF));
            else             a = $urandom;
            dly = $urandom_range(0, 20);
            if (TO_EN && $urandom_range(0, 7) == 0) dly = 255;
            t = find_slave(a);
            ecs = 4'hF;
            if (t < 0) begin
                eerr = 1'b1; elat = 1;
            end else begin
                ecs[t] = 1'b0;
                if (TO_EN && dly > TO) begin
                    eerr = 1'b1; elat = TO + 1;
                end else begin
                    eerr = 1'b0; elat = dly;
                end
            end
            run_txn(a, 1'($urandom), $urandom, 4'($urandom), dly,
                    $urandom, ecs, eerr, elat);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
